regfile_readback: RTL

- Reader side of the register-file datapath. The sequencers write R0..R15; this block reads them back one at a time.
- Drives the datapath read select and captures the 16-bit bus value.
- Shows the captured value on four 7-segment digits.
- Advances on a step button (manual) or a dwell timer (auto). Used for on-board inspection after a test program runs.

---
 rtl/regfile_readback_pkg.sv | 24 ++
 rtl/hexTo7Seg.sv | 39 +++
 rtl/regfile_readback.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/regfile_readback_pkg.sv
// -----------------------------------------------------------------------------
// regfile_readback_pkg
//   Shared definitions for the register-file readback walker:
//   - walker state encoding
//   - default bus width and the register index width
// -----------------------------------------------------------------------------
package regfile_readback_pkg;

  // Register index width: enough for R0..R15.
  localparam int IDX_W      = 4;

  // Default datapath bus width; the 7-segment mapping assumes four nibbles.
  localparam int DATA_W_DEF = 16;

  // Walker states.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SELECT  = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_SHOW    = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

endpackage : regfile_readback_pkg

// File: rtl/hexTo7Seg.sv
// -----------------------------------------------------------------------------
// hexTo7Seg
//   Hex nibble to 7-segment pattern decoder (shared board-level decoder).
//   Segments are active-low, ordered {g, f, e, d, c, b, a}, matching the
//   common-anode displays on the board: "0" is 7'b100_0000.
//
// Ports:
//   hex  in  4  nibble to display
//   seg  out 7  segment pattern, active-low {g,f,e,d,c,b,a}
// -----------------------------------------------------------------------------
module hexTo7Seg (
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  always_comb begin
    seg = 7'b111_1111;
    case (hex)
      4'h0: seg = 7'b100_0000;
      4'h1: seg = 7'b111_1001;
      4'h2: seg = 7'b010_0100;
      4'h3: seg = 7'b011_0000;
      4'h4: seg = 7'b001_1001;
      4'h5: seg = 7'b001_0010;
      4'h6: seg = 7'b000_0010;
      4'h7: seg = 7'b111_1000;
      4'h8: seg = 7'b000_0000;
      4'h9: seg = 7'b001_0000;
      4'hA: seg = 7'b000_1000;
      4'hB: seg = 7'b000_0011;
      4'hC: seg = 7'b100_0110;
      4'hD: seg = 7'b010_0001;
      4'hE: seg = 7'b000_0110;
      4'hF: seg = 7'b000_1110;
      default: seg = 7'b111_1111;
    endcase
  end

endmodule : hexTo7Seg

// File: rtl/regfile_readback.sv
// -----------------------------------------------------------------------------
// regfile_readback
//   Reader side of the register-file datapath. Walks R0..R(NUM_REGS-1) one at
//   a time: drives the datapath read select, lets the bus settle for a cycle,
//   captures the bus value and shows it on four 7-segment digits. Advance is
//   by a rising edge of the step button (manual) or a dwell timer (auto).
//   The walk ends in DONE; it never wraps back to R0 on its own.
//
// Optional feature (macro READBACK_CHECKSUM_EN):
//   defined   - checksum is cleared when a walk starts and XOR-accumulates each
//               captured value; it is final and held while done=1.
//   undefined - no checksum register; checksum output is tied to zero.
//
// Parameters:
//   NUM_REGS      registers walked (2..16)
//   DWELL_CYCLES  clocks each register is shown in auto mode (>=1)
//   DATA_W        bus width (must be 16)
//
// Ports:
//   clk         in   1       system clock
//   reset       in   1       asynchronous, active-high reset
//   start       in   1       begins a walk when sampled in IDLE or DONE
//   step        in   1       synchronised button level; rising edge advances
//   auto_mode   in   1       1 = dwell-timer advance, 0 = step advance
//   rd_data     in   DATA_W  datapath bus value for the selected register
//   rd_sel      out  4       registered read select to the datapath A-mux
//   shown_data  out  DATA_W  last captured register value
//   cur_idx     out  4       index of the register currently shown
//   busy        out  1       high in SELECT, CAPTURE, SHOW
//   done        out  1       high in DONE
//   checksum    out  DATA_W  XOR of captured values (or 0, see above)
//   out0..out3  out  7       7-seg patterns for shown_data nibbles 0..3
// -----------------------------------------------------------------------------
module regfile_readback
  import regfile_readback_pkg::*;
#(
  parameter int NUM_REGS     = 16,
  parameter int DWELL_CYCLES = 50_000_000,
  parameter int DATA_W       = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              step,
  input  logic              auto_mode,
  input  logic [DATA_W-1:0] rd_data,
  output logic [IDX_W-1:0]  rd_sel,
  output logic [DATA_W-1:0] shown_data,
  output logic [IDX_W-1:0]  cur_idx,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] checksum,
  output logic [6:0]        out0,
  output logic [6:0]        out1,
  output logic [6:0]        out2,
  output logic [6:0]        out3
);

  // Elaboration-time parameter checks.
  if (NUM_REGS < 2 || NUM_REGS > 16) begin : g_bad_num_regs
    $error("regfile_readback: NUM_REGS must be 2..16");
  end
  if (DWELL_CYCLES < 1) begin : g_bad_dwell
    $error("regfile_readback: DWELL_CYCLES must be >= 1");
  end
  if (DATA_W != 16) begin : g_bad_width
    $error("regfile_readback: DATA_W must be 16 for the 7-seg mapping");
  end

  localparam int CNT_W = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_REGS - 1);

  state_t           state;
  logic             step_q;
  logic             step_rise;
  logic [CNT_W-1:0] dwell_cnt;
  logic             advance;

  // step_q follows step every cycle, so a held button yields a single rise
  // and a rise outside SHOW is simply lost rather than remembered.
  assign step_rise = step & ~step_q;

  // auto_mode is looked at combinationally, so a toggle inside SHOW switches
  // the advance source on the very next edge without touching the counter.
  assign advance = auto_mode ? (dwell_cnt == DWELL_LAST) : step_rise;

`ifdef READBACK_CHECKSUM_EN
  logic [DATA_W-1:0] checksum_q;
  assign checksum = checksum_q;
`else
  assign checksum = '0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      rd_sel     <= '0;
      cur_idx    <= '0;
      shown_data <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      step_q     <= 1'b0;
      dwell_cnt  <= '0;
`ifdef READBACK_CHECKSUM_EN
      checksum_q <= '0;
`endif
    end else begin
      step_q <= step;

      case (state)
        // IDLE and DONE both (re)start the walk from R0 on start.
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state   <= ST_SELECT;
            cur_idx <= '0;
            rd_sel  <= '0;
            busy    <= 1'b1;
            done    <= 1'b0;
`ifdef READBACK_CHECKSUM_EN
            checksum_q <= '0;
`endif
          end
        end

        // rd_sel changed on entry; give the datapath mux one cycle to settle.
        ST_SELECT: begin
          state <= ST_CAPTURE;
        end

        ST_CAPTURE: begin
          shown_data <= rd_data;
          dwell_cnt  <= '0;
          state      <= ST_SHOW;
`ifdef READBACK_CHECKSUM_EN
          checksum_q <= checksum_q ^ rd_data;
`endif
        end

        ST_SHOW: begin
          if (advance) begin
            if (cur_idx == LAST_IDX) begin
              state <= ST_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              cur_idx <= cur_idx + 1'b1;
              rd_sel  <= rd_sel + 1'b1;
              state   <= ST_SELECT;
            end
          end else if (dwell_cnt != DWELL_LAST) begin
            // Saturate at the terminal count: a long manual dwell followed
            // by a switch to auto then advances immediately instead of
            // waiting for the counter to wrap.
            dwell_cnt <= dwell_cnt + 1'b1;
          end
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Display decode is combinational from the captured value.
  hexTo7Seg u_seg0 (.hex(shown_data[3:0]),   .seg(out0));
  hexTo7Seg u_seg1 (.hex(shown_data[7:4]),   .seg(out1));
  hexTo7Seg u_seg2 (.hex(shown_data[11:8]),  .seg(out2));
  hexTo7Seg u_seg3 (.hex(shown_data[15:12]), .seg(out3));

endmodule : regfile_readback
